// File: rtl/srx_word_if.sv
// srx_word_if: serial line and received-word outputs of the srx_word receiver.
// The master side drives the serial line and observes the receiver outputs.
// The slave side is the receiver itself.
interface srx_word_if;
    logic        rxd;
    logic        rx_vld;
    logic [31:0] rx_data;
    logic        rx_err;

    modport master (output rxd, input rx_vld, input rx_data, input rx_err);
    modport slave  (input rxd, output rx_vld, output rx_data, output rx_err);
endinterface

// File: rtl/srx_word.sv
// srx_word: UART-style byte receiver that assembles four bytes into a 32-bit word.
// The first received byte lands in rx_data[31:24]. A framing error drops the
// byte and any partial word.
// Optional feature macro SRX_TIMEOUT_EN: an idle timeout of TOUT cycles clears a
// partial word. When the macro is undefined, a partial word persists.
module srx_word #(
    parameter logic [15:0] DIVBAUD = 16'd234,
    parameter logic [3:0]  BITNUM  = 4'd10,
    parameter logic [15:0] TOUT    = 16'd4680
) (
    input  logic       s_clk,
    input  logic       s_rst,
    srx_word_if.slave  bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] WAITHI = 3'd4;

    localparam logic [15:0] HALF_BIT = DIVBAUD >> 1;
    localparam logic [15:0] LAST_CNT = DIVBAUD - 16'd1;
    // index of the last data bit: frame minus start and stop bits, minus one
    localparam logic [3:0]  LAST_BIT = BITNUM - 4'd3;

    logic        sync1_r;
    logic        sync2_r;
    logic        prev_r;
    logic [2:0]  settle_r;
    logic        rxd_s;
    logic        fall_s;

    logic [2:0]  state_r;
    logic [15:0] cnt_r;
    logic [3:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic [23:0] partial_r;
    logic [1:0]  byte_cnt_r;
    logic        rx_vld_r;
    logic        rx_err_r;
    logic [31:0] rx_data_r;

`ifdef SRX_TIMEOUT_EN
    logic [15:0] idle_cnt_r;
`else
    logic        unused_tout_s;
    assign unused_tout_s = ^TOUT;
`endif

    assign rxd_s = sync2_r;
    // After reset the synchroniser still holds its forced-high value. settle_r
    // blocks edge detection until prev_r and rxd_s both carry real line
    // samples, so a line that is already low at release is not taken as a
    // start bit.
    assign fall_s = settle_r[2] & prev_r & ~rxd_s;

    // Two-flop synchroniser plus the previous-sample register used for edge detection
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            prev_r   <= 1'b1;
            settle_r <= 3'b000;
        end else begin
            sync1_r  <= bus.rxd;
            sync2_r  <= sync1_r;
            prev_r   <= sync2_r;
            settle_r <= {settle_r[1:0], 1'b1};
        end
    end

    // Frame FSM, bit timing, byte assembly and registered outputs
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_r    <= IDLE;
            cnt_r      <= 16'd0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'd0;
            partial_r  <= 24'd0;
            byte_cnt_r <= 2'd0;
            rx_vld_r   <= 1'b0;
            rx_err_r   <= 1'b0;
            rx_data_r  <= 32'h0;
`ifdef SRX_TIMEOUT_EN
            idle_cnt_r <= 16'd0;
`endif
        end else begin
            rx_vld_r <= 1'b0;
            rx_err_r <= 1'b0;
`ifdef SRX_TIMEOUT_EN
            idle_cnt_r <= 16'd0;
`endif
            case (state_r)
                IDLE: begin
                    cnt_r     <= 16'd0;
                    bit_cnt_r <= 4'd0;
                    if (fall_s) begin
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
`ifdef SRX_TIMEOUT_EN
                    if ((byte_cnt_r != 2'd0) && !fall_s) begin
                        if (idle_cnt_r == TOUT - 16'd1) begin
                            byte_cnt_r <= 2'd0;
                            partial_r  <= 24'd0;
                            idle_cnt_r <= 16'd0;
                        end else begin
                            idle_cnt_r <= idle_cnt_r + 16'd1;
                        end
                    end else begin
                        idle_cnt_r <= 16'd0;
                    end
`endif
                end
                START: begin
                    if (cnt_r == HALF_BIT) begin
                        cnt_r   <= 16'd0;
                        // a line that is high again at mid start bit was a glitch
                        state_r <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_r == LAST_CNT) begin
                        cnt_r   <= 16'd0;
                        shift_r <= {rxd_s, shift_r[7:1]};
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_r <= 4'd0;
                            state_r   <= STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_r == LAST_CNT) begin
                        cnt_r <= 16'd0;
                        if (rxd_s) begin
                            partial_r  <= {partial_r[15:0], shift_r};
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            if (byte_cnt_r == 2'd3) begin
                                rx_data_r <= {partial_r, shift_r};
                                rx_vld_r  <= 1'b1;
                            end else begin
                                rx_data_r <= rx_data_r;
                            end
                            state_r <= IDLE;
                        end else begin
                            rx_err_r   <= 1'b1;
                            byte_cnt_r <= 2'd0;
                            partial_r  <= 24'd0;
                            state_r    <= WAITHI;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                WAITHI: begin
                    if (rxd_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAITHI;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 16'd0;
                end
            endcase
        end
    end

    assign bus.rx_vld  = rx_vld_r;
    assign bus.rx_err  = rx_err_r;
    assign bus.rx_data = rx_data_r;

endmodule

// File: tb/tb_srx_word.sv
// tb_srx_word: drives serial frames into srx_word. Each received word is checked
// against a byte-level model. The model keeps a queue of pending bytes: a bad
// stop bit empties it, every fourth good byte emits a word, and a long gap
// empties it when SRX_TIMEOUT_EN is defined.
module tb_srx_word;

    localparam int BAUD = 234;
    localparam int TOUT = 4680;

    logic s_clk = 1'b0;
    logic s_rst = 1'b1;
    srx_word_if bus ();

    srx_word #(.DIVBAUD(16'd234), .BITNUM(4'd10), .TOUT(16'd4680)) dut (
        .s_clk (s_clk),
        .s_rst (s_rst),
        .bus   (bus)
    );

    always #5 s_clk = ~s_clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_q[$];
    int          err_seen  = 0;
    int          hold_viol = 0;
    logic [31:0] last_data = 32'h0;

    logic [7:0]  m_bytes[$];
    logic [31:0] exp_q[$];
    int          m_err = 0;

    // Output monitor: collect words and error pulses, and note any rx_data change without rx_vld
    always @(negedge s_clk) begin
        if (s_rst) begin
            last_data = bus.rx_data;
        end else begin
            if (bus.rx_vld === 1'b1) got_q.push_back(bus.rx_data);
            else if (bus.rx_data !== last_data) hold_viol++;
            if (bus.rx_err === 1'b1) err_seen++;
            last_data = bus.rx_data;
        end
    end

    task automatic model_byte(input logic [7:0] b, input logic stop);
        if (!stop) begin
            m_bytes.delete();
            m_err++;
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                exp_q.push_back({m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]});
                m_bytes.delete();
            end
        end
    endtask

    task automatic model_gap(input int n);
`ifdef SRX_TIMEOUT_EN
        if (n > TOUT) m_bytes.delete();
`endif
    endtask

    task automatic idle(input int n);
        bus.rxd = 1'b1;
        repeat (n) @(negedge s_clk);
        model_gap(n);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rxd = 1'b0;
        repeat (BAUD) @(negedge s_clk);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            repeat (BAUD) @(negedge s_clk);
        end
        bus.rxd = stop;
        repeat (BAUD) @(negedge s_clk);
        bus.rxd = 1'b1;
        model_byte(b, stop);
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[31:24], 1'b1);
            t = t << 8;
        end
    endtask

    task automatic do_reset();
        bus.rxd = 1'b1;
        s_rst = 1'b1;
        repeat (4) @(negedge s_clk);
        got_q.delete();
        exp_q.delete();
        m_bytes.delete();
        err_seen = 0;
        m_err = 0;
        hold_viol = 0;
        s_rst = 1'b0;
        @(negedge s_clk);
    endtask

    task automatic test_reset();
        bus.rxd = 1'b1;
        s_rst = 1'b1;
        repeat (3) @(negedge s_clk);
        checks++;
        if (bus.rx_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", bus.rx_vld); end
        checks++;
        if (bus.rx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.rx_err); end
        checks++;
        if (bus.rx_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", bus.rx_data); end
        do_reset();
        idle(30);
        checks++;
        if (got_q.size() != 0 || err_seen != 0) begin
            errors++;
            $display("FAIL reset_quiet: got %0d words %0d errs want 0 0", got_q.size(), err_seen);
        end
    endtask

    task automatic test_basic();
        logic [31:0] w;
        do_reset();
        w = 32'h11223344;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31:24], 1'b1);
            w = w << 8;
            idle(int'($urandom_range(0, 300)));
        end
        idle(20);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_data: got %h want %h", got_q[i], exp_q[i]); end
        end
        checks++;
        if (err_seen != 0) begin errors++; $display("FAIL basic_err: got %0d pulses want 0", err_seen); end
    endtask

    task automatic test_glitch();
        do_reset();
        idle(100);
        bus.rxd = 1'b0;
        repeat (50) @(negedge s_clk);
        idle(400);
        checks++;
        if (got_q.size() != 0 || err_seen != 0) begin
            errors++;
            $display("FAIL glitch_quiet: got %0d words %0d errs want 0 0", got_q.size(), err_seen);
        end
        send_word(32'hDEADBEEF);
        idle(20);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL glitch_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL glitch_data: got %h want %h", got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_framing();
        do_reset();
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        idle(int'($urandom_range(10, 200)));
        send_word(32'h01020304);
        idle(20);
        checks++;
        if (err_seen != m_err) begin errors++; $display("FAIL framing_err: got %0d pulses want %0d", err_seen, m_err); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL framing_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL framing_data: got %h want %h", got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        idle(5000);
        send_word(32'h01020304);
        idle(20);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_data: got %h want %h", got_q[i], exp_q[i]); end
        end
        checks++;
        if (err_seen != 0) begin errors++; $display("FAIL timeout_err: got %0d pulses want 0", err_seen); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        idle(int'($urandom_range(0, 100)));
        // second byte 0x0F by hand: bits 0-3 high, reset lands inside low bit 4
        bus.rxd = 1'b0;
        repeat (BAUD) @(negedge s_clk);
        bus.rxd = 1'b1;
        repeat (4 * BAUD) @(negedge s_clk);
        bus.rxd = 1'b0;
        repeat (100) @(negedge s_clk);
        s_rst = 1'b1;
        repeat (20) @(negedge s_clk);
        checks++;
        if (bus.rx_vld !== 1'b0 || bus.rx_data !== 32'h0) begin
            errors++;
            $display("FAIL midreset_hold: got vld=%b data=%h want 0 00000000", bus.rx_vld, bus.rx_data);
        end
        s_rst = 1'b0;
        m_bytes.delete();
        repeat (BAUD - 120 + 3 * BAUD) @(negedge s_clk);
        idle(BAUD + 200);
        send_word(32'hCAFEF00D);
        idle(20);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_data: got %h want %h", got_q[i], exp_q[i]); end
        end
        checks++;
        if (err_seen != 0) begin errors++; $display("FAIL midreset_err: got %0d pulses want 0", err_seen); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int b = 0; b < 8; b++) send_byte(8'(b), 1'b1);
        idle(20);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data: got %h want %h", got_q[i], exp_q[i]); end
        end
        checks++;
        if (hold_viol != 0) begin errors++; $display("FAIL b2b_hold: got %0d unflagged rx_data changes want 0", hold_viol); end
    endtask

    // Watchdog: the whole run is bounded in time
    initial begin
        #(1_000_000 * 10);
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // Test sequence
    initial begin
        bus.rxd = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
